// File: rtl/memoria_programa.sv
// memoria_programa: writable program memory feeding the instruction decoder.
// A single-clock array of PROFUNDIDADE words with a registered read port
// (request/valid) and a programming write port. After reset a clear sequencer
// walks every word, writing zero, before the block raises pronto.
//
// Handshake: the read port has no back-pressure. A request is taken in any
// cycle where pedido=1 and pronto=1; exactly one cycle later valido pulses
// for one cycle with dado/fora_limite describing that request. Without a
// request valido is 0 and dado/fora_limite keep their previous values.
// Requests and writes presented while pronto=0 are dropped silently.
module memoria_programa #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_END  = 5,
  parameter int PROFUNDIDADE = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LARGURA_END-1:0]  endereco,
  input  logic                    pedido,
  output logic [LARGURA_DADO-1:0] dado,
  output logic                    valido,
  output logic                    fora_limite,
  input  logic                    prog_we,
  input  logic [LARGURA_END-1:0]  prog_endereco,
  input  logic [LARGURA_DADO-1:0] prog_dado,
  output logic                    prog_erro,
  output logic                    pronto,
  output logic [0:0]              estado
);

  localparam logic [0:0] LIMPAR = 1'b0;
  localparam logic [0:0] ATIVO  = 1'b1;

  // One extra bit so a depth of exactly 2**LARGURA_END is representable.
  localparam logic [LARGURA_END:0]   LIMITE = (LARGURA_END + 1)'(PROFUNDIDADE);
  localparam logic [LARGURA_END-1:0] ULTIMO = LARGURA_END'(PROFUNDIDADE - 1);

  logic [LARGURA_DADO-1:0] mem [PROFUNDIDADE];

  logic [0:0]              estado_q;
  logic [LARGURA_END-1:0]  contador;
  logic                    ativo;
  logic                    rd_ok;
  logic                    wr_ok;
  logic                    mem_we;
  logic [LARGURA_END-1:0]  mem_end;
  logic [LARGURA_DADO-1:0] mem_dado;

  assign ativo  = (estado_q == ATIVO);
  assign rd_ok  = ({1'b0, endereco} < LIMITE);
  assign wr_ok  = ({1'b0, prog_endereco} < LIMITE);
  assign pronto = ativo;
  assign estado = estado_q;

  // Clear sequencer: step the counter through every word, then settle in ATIVO.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= LIMPAR;
      contador <= '0;
    end else if (estado_q == LIMPAR) begin
      if (contador == ULTIMO) begin
        estado_q <= ATIVO;
      end else begin
        contador <= contador + LARGURA_END'(1);
      end
    end
  end

  // Single write port shared by the clear sequencer and the programming port.
  always_comb begin
    mem_we   = 1'b0;
    mem_end  = '0;
    mem_dado = '0;
    if (!reset && estado_q == LIMPAR) begin
      mem_we  = 1'b1;
      mem_end = contador;
    end else if (!reset && ativo && prog_we && wr_ok) begin
      mem_we   = 1'b1;
      mem_end  = prog_endereco;
      mem_dado = prog_dado;
    end
  end

  // Storage array; the read below samples the old word on a same-cycle write.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_end] <= mem_dado;
    end
  end

  // Registered read port: one result per accepted request, one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      dado        <= '0;
      valido      <= 1'b0;
      fora_limite <= 1'b0;
    end else begin
      valido <= 1'b0;
      if (ativo && pedido) begin
        valido      <= 1'b1;
        fora_limite <= !rd_ok;
        dado        <= rd_ok ? mem[endereco] : '0;
      end
    end
  end

  // Reject flag: pulses the cycle after an out-of-range programming write.
  always_ff @(posedge clock) begin
    if (reset) begin
      prog_erro <= 1'b0;
    end else begin
      prog_erro <= ativo && prog_we && !wr_ok;
    end
  end

endmodule

// File: tb/tb_memoria_programa.sv
// tb_memoria_programa: directed bench for memoria_programa. Two instances share
// the clock and reset: the default 32-word memory and a 20-word memory whose
// upper addresses are out of range. sel_b steers traffic to one of them.
module tb_memoria_programa;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] endereco;
  logic       pedido;
  logic       prog_we;
  logic [4:0] prog_endereco;
  logic [7:0] prog_dado;
  logic       sel_b;

  logic       pedido_a, pedido_b, prog_we_a, prog_we_b;
  logic [7:0] dado_a, dado_b;
  logic       valido_a, valido_b, fora_a, fora_b;
  logic       erro_a, erro_b, pronto_a, pronto_b;
  logic [0:0] estado_a, estado_b;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] last_dado [2];

  assign pedido_a  = pedido  & ~sel_b;
  assign pedido_b  = pedido  &  sel_b;
  assign prog_we_a = prog_we & ~sel_b;
  assign prog_we_b = prog_we &  sel_b;

  memoria_programa dut (
    .clock(clock), .reset(reset), .endereco(endereco), .pedido(pedido_a),
    .dado(dado_a), .valido(valido_a), .fora_limite(fora_a),
    .prog_we(prog_we_a), .prog_endereco(prog_endereco), .prog_dado(prog_dado),
    .prog_erro(erro_a), .pronto(pronto_a), .estado(estado_a)
  );

  memoria_programa #(.LARGURA_DADO(8), .LARGURA_END(5), .PROFUNDIDADE(20)) dut20 (
    .clock(clock), .reset(reset), .endereco(endereco), .pedido(pedido_b),
    .dado(dado_b), .valido(valido_b), .fora_limite(fora_b),
    .prog_we(prog_we_b), .prog_endereco(prog_endereco), .prog_dado(prog_dado),
    .prog_erro(erro_b), .pronto(pronto_b), .estado(estado_b)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compare the selected instance against the oldest expected read result.
  task automatic check_out(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      last_dado[sel_b] = e[7:0];
      chk({tag, "_valido"}, sel_b ? valido_b : valido_a, 1'b1);
      chk({tag, "_dado"}, sel_b ? dado_b : dado_a, e[7:0]);
      chk({tag, "_fora"}, sel_b ? fora_b : fora_a, e[8]);
    end
  endtask

  // Drive a request (left asserted so calls chain back-to-back).
  task automatic req(input string tag, input logic [4:0] a, input logic [7:0] d, input logic fl);
    prog_we  = 1'b0;
    pedido   = 1'b1;
    endereco = a;
    exp_q.push_back({fl, d});
    step();
    check_out(tag);
  endtask

  // Programming write; err is the prog_erro value expected one cycle later.
  task automatic wr(input string tag, input logic [4:0] a, input logic [7:0] d, input logic err);
    pedido        = 1'b0;
    prog_we       = 1'b1;
    prog_endereco = a;
    prog_dado     = d;
    step();
    chk({tag, "_prog_erro"}, sel_b ? erro_b : erro_a, err);
  endtask

  // Quiet cycle: no valido, no prog_erro, dado holds.
  task automatic idle(input string tag);
    pedido  = 1'b0;
    prog_we = 1'b0;
    step();
    chk({tag, "_idle_valido"}, sel_b ? valido_b : valido_a, 1'b0);
    chk({tag, "_idle_erro"}, sel_b ? erro_b : erro_a, 1'b0);
    chk({tag, "_idle_hold"}, sel_b ? dado_b : dado_a, last_dado[sel_b]);
  endtask

  // Count the clear: pronto low for 'depth' edges after reset drops, with
  // a request and a write held asserted the whole time.
  task automatic clear_run(input string tag);
    reset         = 1'b0;
    pedido        = 1'b1;
    endereco      = 5'd7;
    prog_we       = 1'b1;
    prog_endereco = 5'd2;
    prog_dado     = 8'hFF;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk({tag, "_pronto"}, pronto_a, (i == 32) ? 1'b1 : 1'b0);
      chk({tag, "_pronto20"}, pronto_b, (i >= 20) ? 1'b1 : 1'b0);
      chk({tag, "_valido"}, valido_a, 1'b0);
      chk({tag, "_erro"}, erro_a, 1'b0);
    end
    pedido  = 1'b0;
    prog_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pedido = 1'b0; endereco = '0; sel_b = 1'b0;
    prog_we = 1'b0; prog_endereco = '0; prog_dado = '0;
    last_dado[0] = 8'h00;
    last_dado[1] = 8'h00;

    // Reset state.
    step();
    step();
    chk("rst_pronto", pronto_a, 1'b0);
    chk("rst_valido", valido_a, 1'b0);
    chk("rst_dado", dado_a, 8'h00);
    chk("rst_fora", fora_a, 1'b0);
    chk("rst_erro", erro_a, 1'b0);
    chk("rst_estado", estado_a, 1'b0);

    // Clear sequence, then back-to-back reads of cleared words.
    clear_run("clear");
    chk("clear_estado", estado_a, 1'b1);
    req("rb0", 5'd0, 8'h00, 1'b0);
    req("rb17", 5'd17, 8'h00, 1'b0);
    req("rb31", 5'd31, 8'h00, 1'b0);
    req("rb2_ignored_write", 5'd2, 8'h00, 1'b0);
    idle("rb");

    // Program and fetch.
    wr("wr0", 5'd0, 8'b001_100_00, 1'b0);
    wr("wr9", 5'd9, 8'b101_01011, 1'b0);
    req("fetch9", 5'd9, 8'hAB, 1'b0);
    req("fetch0", 5'd0, 8'h30, 1'b0);
    idle("fetch");

    // Read-before-write on the same address.
    wr("wr4", 5'd4, 8'h55, 1'b0);
    prog_we       = 1'b1;
    prog_endereco = 5'd4;
    prog_dado     = 8'hAA;
    pedido        = 1'b1;
    endereco      = 5'd4;
    exp_q.push_back({1'b0, 8'h55});
    step();
    check_out("rbw_old");
    req("rbw_new", 5'd4, 8'hAA, 1'b0);
    idle("rbw");

    // Out of range on the 20-word instance.
    sel_b = 1'b1;
    req("oor25", 5'd25, 8'h00, 1'b1);
    idle("oor25");
    wr("wr19", 5'd19, 8'hC3, 1'b0);
    req("rd19", 5'd19, 8'hC3, 1'b0);
    wr("wr20", 5'd20, 8'h5A, 1'b1);
    idle("wr20_pulse");
    req("rd20", 5'd20, 8'h00, 1'b1);
    req("rd19_again", 5'd19, 8'hC3, 1'b0);
    idle("oor");
    sel_b = 1'b0;

    // Reset mid-operation.
    wr("wr3", 5'd3, 8'h77, 1'b0);
    req("rd3", 5'd3, 8'h77, 1'b0);
    idle("rd3");
    reset = 1'b1;
    step();
    last_dado[0] = 8'h00;
    last_dado[1] = 8'h00;
    chk("rst2_pronto", pronto_a, 1'b0);
    chk("rst2_dado", dado_a, 8'h00);
    chk("rst2_estado", estado_a, 1'b0);
    clear_run("clear2");
    req("rd3_cleared", 5'd3, 8'h00, 1'b0);
    req("rd9_cleared", 5'd9, 8'h00, 1'b0);
    idle("end");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
